// File: rtl/yutorina_bus_if_wb_if.sv
// Arbitrated system-bus port of the CPU memory interface: request/grant,
// address strobe, ready and the address/data lines, all strobes active-low.
interface yutorina_bus_if_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic              bus_rdy_;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_w_data;
  logic [DATA_W-1:0] bus_r_data;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_w_data,
    input  bus_grnt_, bus_rdy_, bus_r_data
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_w_data,
    output bus_grnt_, bus_rdy_, bus_r_data
  );
endinterface

// File: rtl/yutorina_bus_if_wb.sv
// MEM-stage bus interface: local SPM decode, posted-write buffer drained by a
// bus master FSM, blocking reads ordered behind buffered writes, bus timeout.
module yutorina_bus_if_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 30,
  parameter int IDX_W    = 3,
  parameter int SPM_IDX  = 1,
  parameter int WB_DEPTH = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                as_,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   w_data,
  output logic [DATA_W-1:0]   r_data,
  output logic                busy,
  output logic                err,
  output logic                spm_as_,
  output logic                spm_rw,
  output logic [ADDR_W-1:0]   spm_addr,
  output logic [DATA_W-1:0]   spm_w_data,
  input  logic [DATA_W-1:0]   spm_r_data,
  yutorina_bus_if_wb_if.master bus
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] buf_addr_q [WB_DEPTH];
  logic [ADDR_W-1:0] buf_addr_d [WB_DEPTH];
  logic [DATA_W-1:0] buf_data_q [WB_DEPTH];
  logic [DATA_W-1:0] buf_data_d [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hold_q, hold_d;
  logic [DATA_W-1:0] r_buf_q, r_buf_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              bus_req_q, bus_req_d, bus_as_q, bus_as_d, bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_w_data_q, bus_w_data_d;

  logic spm_sel, hold_c, acc_c, rdy_c, tmo_hit, xfer_done, pop, rd_done;
  logic full_c, bus_wr_req, bus_rd_req, push, rd_pend, have_wr, have_work;

  // Reset is folded into the request decode so busy reflects an empty buffer
  // during the reset cycle itself.
  always_comb begin
    spm_sel    = (addr[ADDR_W-1 -: IDX_W] == IDX_W'(SPM_IDX));
    hold_c     = hold_q && !rst;
    acc_c      = (state_q == ACCESS) && !rst;
    rdy_c      = acc_c && !bus.bus_rdy_;
    tmo_hit    = acc_c && bus.bus_rdy_ && (tmo_q == TMO_W'(TIMEOUT - 1));
    xfer_done  = rdy_c || tmo_hit;
    pop        = xfer_done && bus_rw_q;
    rd_done    = xfer_done && !bus_rw_q;
    full_c     = !rst && (count_q == CNT_W'(WB_DEPTH));
    bus_wr_req = !as_ && !spm_sel && rw && !hold_c;
    bus_rd_req = !as_ && !spm_sel && !rw && !hold_c;
    push       = bus_wr_req && (!full_c || pop);
    rd_pend    = bus_rd_req && !rd_done;
    busy       = (bus_wr_req && !push) || rd_pend;
    err        = tmo_hit;

    r_data = '0;
    if (!as_ && spm_sel)
      r_data = spm_r_data;
    else if (!as_ && !rw && hold_c)
      r_data = r_buf_q;
    else if (rd_done)
      r_data = rdy_c ? bus.bus_r_data : '0;

    spm_as_    = !(!as_ && spm_sel && !hold_c);
    spm_rw     = rw;
    spm_addr   = addr;
    spm_w_data = w_data;

    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    if (push) begin
      buf_addr_d[wr_ptr_q] = addr;
      buf_data_d[wr_ptr_q] = w_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    hold_d  = stall && (hold_c || (!as_ && !busy));
    r_buf_d = r_buf_q;
    if (rd_done)
      r_buf_d = rdy_c ? bus.bus_r_data : '0;
  end

  // Master FSM: the buffer head always wins over a pending read, which keeps
  // reads ordered behind every posted write.
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_as_d     = 1'b1;
    bus_rw_d     = bus_rw_q;
    bus_addr_d   = bus_addr_q;
    bus_w_data_d = bus_w_data_q;
    tmo_d        = tmo_q;
    have_wr      = (count_d != '0);
    have_work    = have_wr || rd_pend;

    case (state_q)
      IDLE: begin
        if (have_work) begin
          state_d   = REQ;
          bus_req_d = 1'b0;
        end
      end
      REQ: begin
        if (!bus.bus_grnt_) begin
          state_d  = ACCESS;
          bus_as_d = 1'b0;
          tmo_d    = '0;
        end
      end
      ACCESS: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tmo_hit || (rdy_c && !have_work)) begin
          state_d      = IDLE;
          bus_req_d    = 1'b1;
          bus_addr_d   = '0;
          bus_w_data_d = '0;
        end else if (rdy_c) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == REQ && state_q != REQ) begin
      if (have_wr) begin
        bus_rw_d     = 1'b1;
        bus_addr_d   = buf_addr_d[rd_ptr_d];
        bus_w_data_d = buf_data_d[rd_ptr_d];
      end else begin
        bus_rw_d     = 1'b0;
        bus_addr_d   = addr;
        bus_w_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= 1'b0;
      r_buf_q      <= '0;
      tmo_q        <= '0;
      bus_req_q    <= 1'b1;
      bus_as_q     <= 1'b1;
      bus_rw_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_w_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      r_buf_q      <= r_buf_d;
      tmo_q        <= tmo_d;
      bus_req_q    <= bus_req_d;
      bus_as_q     <= bus_as_d;
      bus_rw_q     <= bus_rw_d;
      bus_addr_q   <= bus_addr_d;
      bus_w_data_q <= bus_w_data_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  assign bus.bus_req_   = bus_req_q;
  assign bus.bus_as_    = bus_as_q;
  assign bus.bus_rw     = bus_rw_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_w_data = bus_w_data_q;
endmodule

// File: tb/tb_yutorina_bus_if_wb.sv
// Directed bench for yutorina_bus_if_wb: combinational SPM vector table plus
// hand-sequenced bus scenarios against a small latency-programmable bus slave.
module tb_yutorina_bus_if_wb;
  localparam int DW = 32;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          as_ = 1'b1;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] spm_r_data = '0;
  logic [DW-1:0] r_data;
  logic          busy, err, spm_as_, spm_rw;
  logic [AW-1:0] spm_addr;
  logic [DW-1:0] spm_w_data;

  yutorina_bus_if_wb_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

  yutorina_bus_if_wb #(
    .DATA_W(DW), .ADDR_W(AW), .IDX_W(3), .SPM_IDX(1), .WB_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .as_(as_), .rw(rw), .addr(addr),
    .w_data(w_data), .r_data(r_data), .busy(busy), .err(err),
    .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr),
    .spm_w_data(spm_w_data), .spm_r_data(spm_r_data), .bus(bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus slave: grants whenever requested (if enabled), raises ready on the
  // lat-th ACCESS cycle, logs every address strobe.
  int          lat = 4;
  bit          rdy_en = 1'b1;
  bit          grant_en = 1'b1;
  bit          mon_en = 1'b0;
  logic [31:0] rd_val = '0;
  int          as_cnt = 0, rdy_cnt = 0, cyc = 0, req_hi = 0;
  bit          in_acc = 1'b0;
  logic [62:0] log_ent [64];
  int          log_rdy [64];

  initial begin
    bif.bus_grnt_  = 1'b1;
    bif.bus_rdy_   = 1'b1;
    bif.bus_r_data = 32'hDEAD0BAD;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        in_acc       = 1'b0;
        bif.bus_rdy_  = 1'b1;
        bif.bus_grnt_ = 1'b1;
      end else begin
        bif.bus_grnt_ = grant_en ? bif.bus_req_ : 1'b1;
        if (!bif.bus_as_) begin
          in_acc = 1'b1;
          cyc    = 1;
          if (as_cnt < 64) begin
            log_ent[as_cnt] = {bif.bus_rw, bif.bus_addr, bif.bus_w_data};
            log_rdy[as_cnt] = rdy_cnt;
          end
          as_cnt++;
        end else if (in_acc) begin
          cyc++;
        end
        if (in_acc && rdy_en && cyc == lat) begin
          bif.bus_rdy_   = 1'b0;
          bif.bus_r_data = rd_val;
          rdy_cnt++;
          in_acc = 1'b0;
        end else begin
          bif.bus_rdy_   = 1'b1;
          bif.bus_r_data = 32'hDEAD0BAD;
        end
        if (mon_en && bif.bus_req_) req_hi++;
      end
    end
  end

  function automatic logic [AW-1:0] ba(input int i);
    return {3'd2, 27'(i * 4)};
  endfunction

  function automatic logic [DW-1:0] dv(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic cpu(input logic a, input logic r, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    as_ = a; rw = r; addr = ad; w_data = d;
    #1;
  endtask

  task automatic wait_not_busy(input string nm, input int bound);
    bit done;
    done = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (!busy) begin done = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    chk(nm, done, 1'b1);
  endtask

  task automatic wait_rdy(input string nm, input int target);
    for (int k = 0; k < 300; k++) begin
      if (rdy_cnt >= target) break;
      @(negedge clk);
      #1;
    end
    chk(nm, rdy_cnt >= target, 1'b1);
  endtask

  typedef struct {
    logic          a_n;
    logic          rw;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic [DW-1:0] srd;
    logic          e_sas;
    logic          e_busy;
    logic [DW-1:0] e_rd;
    logic          chk_rd;
  } vec_t;

  vec_t vt [6];

  initial begin
    int base_as, base_rdy, base_hi;

    vt[0] = '{1'b1, 1'b0, 30'h0,                 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
    vt[1] = '{1'b0, 1'b0, {3'd1, 27'h10},        32'h0,        32'h1234,     1'b0, 1'b0, 32'h1234,     1'b1};
    vt[2] = '{1'b0, 1'b1, {3'd1, 27'h3FF},       32'hDEADBEEF, 32'h55,       1'b0, 1'b0, 32'h0,        1'b0};
    vt[3] = '{1'b0, 1'b0, {3'd1, 27'h7FFFFFF},   32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1};
    vt[4] = '{1'b1, 1'b0, {3'd1, 27'h10},        32'h0,        32'h1234,     1'b1, 1'b0, 32'h0,        1'b0};
    vt[5] = '{1'b0, 1'b0, {3'd1, 27'h0},         32'h0,        32'h0000ABCD, 1'b0, 1'b0, 32'h0000ABCD, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_bus_req_", bif.bus_req_, 1'b1);
    chk("rst_bus_as_", bif.bus_as_, 1'b1);
    chk("rst_bus_rw", bif.bus_rw, 1'b0);
    chk("rst_bus_addr", bif.bus_addr, 30'h0);
    chk("rst_bus_w_data", bif.bus_w_data, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      as_ = vt[i].a_n; rw = vt[i].rw; addr = vt[i].ad; w_data = vt[i].wd;
      spm_r_data = vt[i].srd;
      #1;
      chk("vec_spm_as_", spm_as_, vt[i].e_sas);
      chk("vec_busy", busy, vt[i].e_busy);
      chk("vec_spm_rw", spm_rw, vt[i].rw);
      chk("vec_spm_addr", spm_addr, vt[i].ad);
      chk("vec_spm_w_data", spm_w_data, vt[i].wd);
      if (vt[i].chk_rd) chk("vec_r_data", r_data, vt[i].e_rd);
      chk("vec_bus_req_idle", bif.bus_req_, 1'b1);
    end
    cpu(1'b1, 1'b0, '0, '0);

    // Five back-to-back posted writes into a four-deep buffer.
    base_as = as_cnt; base_rdy = rdy_cnt; base_hi = req_hi;
    for (int i = 0; i < 4; i++) begin
      cpu(1'b0, 1'b1, ba(i), dv(i));
      chk("wb_post_busy", busy, 1'b0);
      if (i == 0) mon_en = 1'b1;
    end
    cpu(1'b0, 1'b1, ba(4), dv(4));
    chk("wb_full_busy", busy, 1'b1);
    @(negedge clk);
    #1;
    chk("wb_pop_frees_slot", busy, 1'b0);
    cpu(1'b1, 1'b0, '0, '0);
    wait_rdy("wb_drain_done", base_rdy + 5);
    mon_en = 1'b0;
    chk("wb_req_continuous", req_hi - base_hi, 0);
    @(negedge clk);
    #1;
    chk("wb_req_released", bif.bus_req_, 1'b1);
    chk("wb_xfer_count", as_cnt - base_as, 5);
    for (int i = 0; i < 5; i++) chk("wb_xfer_order", log_ent[base_as + i], {1'b1, ba(i), dv(i)});

    // Read queued behind two posted writes.
    base_as = as_cnt; base_rdy = rdy_cnt;
    rd_val = 32'h0000CAFE;
    cpu(1'b0, 1'b1, ba(8), dv(8));
    chk("rd_post0_busy", busy, 1'b0);
    cpu(1'b0, 1'b1, ba(9), dv(9));
    chk("rd_post1_busy", busy, 1'b0);
    cpu(1'b0, 1'b0, ba(16), '0);
    chk("rd_wait_busy", busy, 1'b1);
    wait_not_busy("rd_complete", 200);
    chk("rd_data", r_data, 32'h0000CAFE);
    chk("rd_no_err", err, 1'b0);
    chk("rd_after_writes", log_rdy[base_as + 2] - base_rdy, 2);
    chk("rd_bus_cmd", log_ent[base_as + 2][62:32], {1'b0, ba(16)});
    cpu(1'b1, 1'b0, '0, '0);

    // Read that never gets ready.
    rdy_en = 1'b0;
    base_as = as_cnt;
    cpu(1'b0, 1'b0, ba(20), '0);
    wait_not_busy("tmo_complete", 50);
    chk("tmo_err", err, 1'b1);
    chk("tmo_r_data", r_data, 32'h0);
    chk("tmo_cycles", cyc, 8);
    cpu(1'b1, 1'b0, '0, '0);
    chk("tmo_err_one_cycle", err, 1'b0);
    chk("tmo_bus_req_", bif.bus_req_, 1'b1);
    chk("tmo_one_strobe", as_cnt - base_as, 1);
    rdy_en = 1'b1;

    // Read completing under stall is held without reissue.
    base_as = as_cnt;
    stall = 1'b1;
    cpu(1'b0, 1'b0, ba(24), '0);
    wait_not_busy("hold_rd_complete", 200);
    chk("hold_rd_first", r_data, 32'h0000CAFE);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      #1;
      chk("hold_busy", busy, 1'b0);
      chk("hold_r_data", r_data, 32'h0000CAFE);
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("hold_last_r_data", r_data, 32'h0000CAFE);
    spm_r_data = 32'h77;
    cpu(1'b0, 1'b0, {3'd1, 27'h20}, '0);
    chk("hold_cleared_spm", spm_as_, 1'b0);
    cpu(1'b1, 1'b0, '0, '0);
    repeat (10) @(negedge clk);
    chk("hold_no_reissue", as_cnt - base_as, 1);

    // Write completing under stall is pushed exactly once.
    base_as = as_cnt; base_rdy = rdy_cnt;
    stall = 1'b1;
    cpu(1'b0, 1'b1, ba(28), dv(28));
    chk("hold_wr_busy", busy, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("hold_wr_busy", busy, 1'b0);
    end
    @(negedge clk);
    stall = 1'b0;
    cpu(1'b1, 1'b0, '0, '0);
    wait_rdy("hold_wr_drain", base_rdy + 1);
    repeat (10) @(negedge clk);
    chk("hold_wr_single", as_cnt - base_as, 1);
    chk("hold_wr_entry", log_ent[base_as], {1'b1, ba(28), dv(28)});

    // Reset mid-transfer with three writes buffered.
    base_as = as_cnt;
    for (int i = 0; i < 3; i++) begin
      cpu(1'b0, 1'b1, ba(32 + i), dv(32 + i));
      chk("rst_fill_busy", busy, 1'b0);
    end
    @(negedge clk);
    as_ = 1'b1; rst = 1'b1; grant_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_bus_req_", bif.bus_req_, 1'b1);
    chk("rst_mid_bus_as_", bif.bus_as_, 1'b1);
    chk("rst_mid_inflight", as_cnt - base_as, 1);
    base_rdy = rdy_cnt;
    for (int i = 0; i < 4; i++) begin
      cpu(1'b0, 1'b1, ba(40 + i), dv(40 + i));
      chk("rst_empty_busy", busy, 1'b0);
    end
    cpu(1'b0, 1'b1, ba(44), dv(44));
    chk("rst_refill_full", busy, 1'b1);
    cpu(1'b1, 1'b0, '0, '0);
    grant_en = 1'b1;
    wait_rdy("rst_drain", base_rdy + 4);
    repeat (10) @(negedge clk);
    chk("rst_xfer_count", as_cnt - base_as, 5);
    for (int i = 0; i < 4; i++) chk("rst_xfer_order", log_ent[base_as + 1 + i], {1'b1, ba(40 + i), dv(40 + i)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/yutorina_bus_if_wb.md
YUTORINA_BUS_IF_WB -- requirements
Module: yutorina_bus_if_wb

Interface
REQ-001 Parameter DATA_W, default 32: CPU, SPM and bus data width.
REQ-002 Parameter ADDR_W, default 30: word address width.
REQ-003 Parameter IDX_W, default 3: slave-index field width, taken as addr[ADDR_W-1 -: IDX_W].
REQ-004 Parameter SPM_IDX, default 1: slave index decoded as local SPM.
REQ-005 Parameter WB_DEPTH, default 4 (power of 2, >=2): posted-write buffer entries.
REQ-006 Parameter TIMEOUT, default 255 (>=1): maximum ACCESS cycles without bus_rdy_.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 stall  in  1  pipeline stall, high = MEM stage holds its request.
REQ-010 as_, rw  in  1 each  CPU strobe (low = request); rw 0 = read, 1 = write.
REQ-011 addr  in  ADDR_W / w_data  in  DATA_W / r_data  out  DATA_W  CPU address, write data, read data.
REQ-012 busy  out  1 / err  out  1  CPU must wait / one-cycle bus-timeout pulse.
REQ-013 spm_as_, spm_rw  out  1 / spm_addr  out  ADDR_W / spm_w_data  out, spm_r_data  in  DATA_W  SPM port.
REQ-014 bus_req_  out, bus_grnt_  in, bus_as_  out, bus_rw  out, bus_rdy_  in  1 each  arbiter/bus handshake, all active-low except bus_rw.
REQ-015 bus_addr  out  ADDR_W / bus_w_data  out, bus_r_data  in  DATA_W  bus address and data.

Function
REQ-016 SPM access (as_=0, index=SPM_IDX, HOLD=0): spm_as_=0 same cycle, spm_rw=rw, spm_addr=addr, spm_w_data=w_data, r_data=spm_r_data on read, busy=0; independent of buffer state.
REQ-017 Bus write, HOLD=0, buffer not full: entry {addr,w_data} pushed at clock edge, busy=0 that cycle.
REQ-018 Bus write, buffer full: busy=1, no push; pushed in first cycle a slot is free, including a cycle where a pop frees it.
REQ-019 Bus read: busy=1 until buffer empty and read completes; read issued only when buffer empty (write-before-read ordering).
REQ-020 Read completion cycle (ACCESS, bus_rdy_=0, read): r_data=bus_r_data, busy=0, r_buf<=bus_r_data.
REQ-021 HOLD flag: set at edge where CPU request completes (busy=0, as_=0) with stall=1; while set, busy=0, no push, no SPM strobe, r_data=r_buf for bus reads, spm_r_data for SPM reads; cleared at first edge with stall=0.
REQ-022 Master FSM states IDLE, REQ, ACCESS; buffer head and pending read served in that order.
REQ-023 IDLE: work available -> REQ; bus_req_<=0, bus_rw, bus_addr, bus_w_data loaded from buffer head or pending read.
REQ-024 REQ: bus_grnt_=0 -> ACCESS, bus_as_<=0 for exactly one cycle; else remain.
REQ-025 ACCESS: bus_rdy_=0 -> write pops head; if more work, reload bus_addr/bus_rw/bus_w_data, keep bus_req_=0, go REQ; else bus_req_<=1, bus_addr<=0, bus_w_data<=0, go IDLE.
REQ-026 Timeout counter cleared on entering ACCESS, increments each ACCESS cycle; reaching TIMEOUT without bus_rdy_: err=1 one cycle, write entry discarded, read completes with r_data=0, FSM to IDLE, bus_req_<=1.
REQ-027 Buffer count 0..WB_DEPTH; simultaneous push and pop keeps count; pointers wrap modulo WB_DEPTH.

Reset
REQ-028 rst=1 at edge: FSM IDLE, buffer empty, HOLD=0, counter 0, r_buf=0, bus_req_=1, bus_as_=1, bus_rw=0, bus_addr=0, bus_w_data=0, err=0; discards any in-flight transfer.
REQ-029 During reset cycle and after: busy follows REQ-016..019 from empty state; spm_as_ follows inputs combinationally.

Verification
REQ-030 SPM read addr index 1, spm_r_data=0x1234 -> same-cycle spm_as_=0, r_data=0x1234, busy=0, bus_req_ stays 1.
REQ-031 Five bus writes back-to-back, grant held, rdy after 3 cycles each, WB_DEPTH=4 -> first four busy=0, fifth busy=1 until first pop, bus_req_ low continuously until buffer empty.
REQ-032 Two posted writes then bus read -> read bus_as_ only after second write's bus_rdy_; bus_r_data=0xCAFE returned with busy=0 that cycle.
REQ-033 Read completes with stall=1 for 3 cycles -> r_data=0xCAFE held, busy=0, no second bus_as_, no duplicate push; HOLD clears when stall=0.
REQ-034 TIMEOUT=8, bus_rdy_ never asserted on read -> err pulse after 8 ACCESS cycles, r_data=0, busy=0, bus_req_=1.
REQ-035 rst asserted in ACCESS with 3 buffered writes -> next cycle bus_req_=1, bus_as_=1, count 0, busy=0 for new write.
